huffman_frame_ctrl: RTL
=======================

# huffman_frame_ctrl

Frame-level sequencer for the Huffman encoder datapath. It accepts a stream of 4-bit symbols and builds a 16-bin frequency histogram over a fixed-length frame. It hands the histogram to the tree builder through a start/done handshake, then gates the next frame of symbols into the encoder while counting them for the following build. It sits between the symbol source and the Huffman tree-builder/encoder pair and owns all phase control, the histogram storage and build-timeout supervision.

## Interface
- FRAME_LEN, 64: symbols per frame; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of each histogram bin.
- TIMEOUT, 1023: maximum BUILD-phase cycles to wait for Build_done; must be at least 1.
- Clk_in  in  1  single clock; all logic on its rising edge.
- n_Rst  in  1  reset, synchronous, active-low.
- Start  in  1  one-cycle start request; honoured only in IDLE.
- Stop  in  1  one-cycle request to halt at the end of the current ENCODE frame.
- Data_in  in  4  input symbol.
- Data_vld  in  1  Data_in valid.
- Data_rdy  out  1  symbol can be accepted; a symbol is accepted when Data_vld and Data_rdy are both high.
- Hist_addr  in  4  histogram bin select.
- Hist_data  out  CNT_W  registered value of bin Hist_addr.
- Build_start  out  1  one-cycle pulse telling the builder to read the histogram.
- Build_done  in  1  builder finished; the tree is loaded into the encoder.
- Enc_en  out  1  Enc_sym is valid for the encoder.
- Enc_sym  out  4  symbol forwarded to the encoder.
- Busy  out  1  state is not IDLE.
- Phase  out  2  0 = IDLE, 1 = COUNT, 2 = BUILD, 3 = ENCODE.
- Err  out  1  sticky build-timeout flag.
- Frame_cnt  out  8  number of completed ENCODE frames; wraps from 255 to 0.

## Operation
- Reset (n_Rst=0 at a clock edge) puts the block in IDLE. Every output is 0, all 16 bins are 0, and the sample counter, timeout counter and stop latch are 0.
- IDLE
  - Data_rdy=0.
  - Start moves the block to COUNT and clears the bins, sample counter, Err and Frame_cnt.
- COUNT
  - Data_rdy=1.
  - Each accepted symbol increments bin[Data_in] and the sample counter.
  - The FRAME_LEN-th acceptance moves the block to BUILD.
- BUILD
  - Data_rdy=0.
  - Build_start is high on the first BUILD cycle only.
  - Build_done moves the block to ENCODE and zeroes all bins and the sample counter on that transition edge.
  - If Build_done has not been seen by the end of cycle TIMEOUT (entry cycle counts as 1), the block sets Err=1 and goes to IDLE.
  - Build_done on exactly cycle TIMEOUT is accepted and Err stays 0.
- ENCODE
  - Data_rdy=1.
  - Each accepted symbol is forwarded to the encoder and counted into the bins, as in COUNT.
  - On the FRAME_LEN-th acceptance, Frame_cnt increments.
  - At that point, if the stop latch is set, the block goes to IDLE and clears the latch; otherwise it goes to BUILD.
- Stop
  - Latched in COUNT, BUILD or ENCODE; ignored in IDLE.
  - Takes effect only at the end of an ENCODE frame.
  - Stop on the final acceptance cycle of an ENCODE frame takes effect on that same frame end.
- Start outside IDLE is ignored. Start and Stop together in IDLE: Start is honoured and Stop is not latched.
- Build_done outside BUILD is ignored.
- Bins saturate at 2^CNT_W-1 and never wrap.
- Hist_data can be read in any state. It returns the bin value before any same-cycle increment.

## Timing
- Data_rdy is a combinational decode of the state.
- Acceptance at cycle t:
  - the bin increment is visible on Hist_data at t+2 (addr held from t+1);
  - Enc_en=1 and Enc_sym=Data_in(t) at t+1 when the state is ENCODE; otherwise Enc_en=0 at t+1.
- Last COUNT/ENCODE acceptance at cycle t:
  - Phase changes at t+1;
  - Build_start=1 at t+1 only, when the next state is BUILD;
  - Data_rdy=0 from t+1.
- Build_done at cycle t: Phase=3, Data_rdy=1 and all bins 0 at t+1.
- Timeout with BUILD entered at cycle e: Err=1, Phase=0 and Busy=0 at e+TIMEOUT.
- Hist_data has one cycle of latency from Hist_addr.
- Synchronous reset overrides everything, including mid-frame and mid-BUILD. Reset during BUILD produces no Build_start.

## Test plan
- FRAME_LEN=8, TIMEOUT=16. Start, then symbols 9,1,2,3,4,5,6,9 with Data_vld held high → Phase sequence 1→2; Build_start is one pulse one cycle after the 8th symbol; bin9=2, bins 1..6 =1, other bins 0.
- Build_done 5 cycles after Build_start, then 8 symbols of 0 → Enc_en high for 8 cycles, each one cycle after its acceptance, with Enc_sym=0; bin0=8, all other bins 0; Frame_cnt=1; Phase returns to 2.
- No Build_done for 16 BUILD cycles → Err=1 and Phase=0 on BUILD cycle 16. A following Start clears Err. Build_done on exactly cycle 16 → ENCODE and Err=0.
- Stop pulse mid-COUNT → the block completes COUNT, BUILD and one ENCODE frame, then goes IDLE with Busy=0 and Frame_cnt=1. Start while busy has no effect.
- FRAME_LEN=255, CNT_W=8, all 255 symbols = 15 → bin15=255 with no wrap. A reset mid-ENCODE → every output 0 and bin15 reads 0.
- Data_vld toggled every other cycle in ENCODE → exactly FRAME_LEN Enc_en pulses per frame. Symbols presented during BUILD are not accepted and not counted.

Source files
------------

// File: rtl/huffman_frame_ctrl.sv
// -----------------------------------------------------------------------------
// huffman_frame_ctrl
//
// Frame-level sequencer for the Huffman encoder datapath. It counts a fixed
// length frame of 4-bit symbols into a 16-bin histogram and hands that
// histogram to the tree builder (Build_start / Build_done). It then gates the
// next frame of symbols into the encoder while counting them for the build
// that follows. It also supervises the build with a cycle timeout.
//
// Phases: IDLE -> COUNT -> BUILD -> ENCODE -> BUILD -> ENCODE ... -> IDLE
//
// Ports
//   Clk_in      : single clock, rising edge
//   n_Rst       : synchronous active-low reset
//   Start       : one-cycle run request, honoured in IDLE only
//   Stop        : one-cycle request to halt at the end of the current ENCODE frame
//   Data_in     : input symbol
//   Data_vld    : Data_in valid
//   Data_rdy    : symbol can be accepted (accept = Data_vld & Data_rdy)
//   Hist_addr   : histogram bin select
//   Hist_data   : registered value of bin Hist_addr (one cycle latency)
//   Build_start : one-cycle pulse asking the builder to read the histogram
//   Build_done  : builder finished, tree is loaded into the encoder
//   Enc_en      : Enc_sym is valid for the encoder
//   Enc_sym     : symbol forwarded to the encoder
//   Busy        : state is not IDLE
//   Phase       : 0 IDLE, 1 COUNT, 2 BUILD, 3 ENCODE
//   Err         : sticky build-timeout flag
//   Frame_cnt   : completed ENCODE frames, wraps at 256
// -----------------------------------------------------------------------------
module huffman_frame_ctrl #(
  parameter int FRAME_LEN = 64,   // symbols per frame, 2 .. 2**CNT_W-1
  parameter int CNT_W     = 8,    // histogram bin width
  parameter int TIMEOUT   = 1023  // max BUILD cycles to wait for Build_done, >= 1
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Start,
  input  logic             Stop,
  input  logic [3:0]       Data_in,
  input  logic             Data_vld,
  output logic             Data_rdy,
  input  logic [3:0]       Hist_addr,
  output logic [CNT_W-1:0] Hist_data,
  output logic             Build_start,
  input  logic             Build_done,
  output logic             Enc_en,
  output logic [3:0]       Enc_sym,
  output logic             Busy,
  output logic [1:0]       Phase,
  output logic             Err,
  output logic [7:0]       Frame_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_BUILD  = 2'd2,
    S_ENCODE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bins_q [16];
  logic [CNT_W-1:0]   bins_d [16];
  logic [CNT_W-1:0]   samp_q, samp_d;       // symbols accepted in this frame
  logic [TMO_W-1:0]   tmo_q, tmo_d;         // current BUILD cycle, entry cycle = 1
  logic               stop_q, stop_d;
  logic               err_q, err_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               build_start_q, build_start_d;
  logic               enc_en_q, enc_en_d;
  logic [3:0]         enc_sym_q, enc_sym_d;
  logic [CNT_W-1:0]   hist_data_q, hist_data_d;

  logic accept;
  logic last_accept;

  assign Data_rdy    = (state_q == S_COUNT) || (state_q == S_ENCODE);
  assign accept      = Data_vld && Data_rdy;
  assign last_accept = accept && (samp_q == CNT_W'(FRAME_LEN - 1));

  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    bins_d        = bins_q;
    samp_d        = samp_q;
    tmo_d         = tmo_q;
    stop_d        = stop_q;
    err_d         = err_q;
    frame_cnt_d   = frame_cnt_q;

    // Counting is identical in COUNT and ENCODE; bins saturate instead of wrap.
    if (accept) begin
      samp_d = samp_q + 1'b1;
      if (bins_q[Data_in] != {CNT_W{1'b1}}) begin
        bins_d[Data_in] = bins_q[Data_in] + 1'b1;
      end
    end

    if ((state_q != S_IDLE) && Stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // A Start arriving with Stop clears the latch, so Stop is not kept.
        if (Start) begin
          state_d     = S_COUNT;
          bins_d      = '{default: '0};
          samp_d      = '0;
          err_d       = 1'b0;
          frame_cnt_d = 8'd0;
          stop_d      = 1'b0;
        end
      end
      S_COUNT: begin
        if (last_accept) begin
          state_d = S_BUILD;
          tmo_d   = TMO_W'(1);
        end
      end
      S_BUILD: begin
        if (Build_done) begin
          state_d = S_ENCODE;
          bins_d  = '{default: '0};
          samp_d  = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ENCODE: begin
        if (last_accept) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          // A Stop on this very cycle still ends the run here.
          if (stop_q || Stop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_BUILD;
            tmo_d   = TMO_W'(1);
          end
        end
      end
    endcase

    build_start_d = (state_d == S_BUILD) && (state_q != S_BUILD);
    enc_en_d      = accept && (state_q == S_ENCODE);
    enc_sym_d     = enc_en_d ? Data_in : enc_sym_q;
    // Read the pre-update bin so a same-cycle increment is not visible yet.
    hist_data_d   = bins_q[Hist_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge Clk_in) begin
    if (!n_Rst) begin
      state_q       <= S_IDLE;
      // NOTE: the histogram is a register array that must read back 0 right
      // after reset, so it is reset here rather than mapped to a RAM.
      bins_q        <= '{default: '0};
      samp_q        <= '0;
      tmo_q         <= '0;
      stop_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= 8'd0;
      build_start_q <= 1'b0;
      enc_en_q      <= 1'b0;
      enc_sym_q     <= 4'd0;
      hist_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      bins_q        <= bins_d;
      samp_q        <= samp_d;
      tmo_q         <= tmo_d;
      stop_q        <= stop_d;
      err_q         <= err_d;
      frame_cnt_q   <= frame_cnt_d;
      build_start_q <= build_start_d;
      enc_en_q      <= enc_en_d;
      enc_sym_q     <= enc_sym_d;
      hist_data_q   <= hist_data_d;
    end
  end

  assign Hist_data   = hist_data_q;
  assign Build_start = build_start_q;
  assign Enc_en      = enc_en_q;
  assign Enc_sym     = enc_sym_q;
  assign Busy        = (state_q != S_IDLE);
  assign Phase       = state_q;
  assign Err         = err_q;
  assign Frame_cnt   = frame_cnt_q;

endmodule
